l2_responder: RTL and testbench

Word-addressed L2 responder at the memory end of the two-core coherence path. It accepts the single merged read or write request that the coherence arbiter forwards from L1A or L1B. It holds the shared L2 busy line high for a fixed access latency, then returns read data or commits write data. The coherence block depends on this busy/data handshake to stall the active core and lock out the other one.

---
 rtl/l2_pkg.sv | 19 +
 rtl/l2_word_ram.sv | 37 +++
 rtl/l2_responder.sv | 138 +++++++++++++
 tb/tb_l2_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types and widths for the L2 responder
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int L2_ADDR_W = 10;
  localparam int CNT_W     = 16;
  localparam int LAT_W     = 4;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/l2_word_ram.sv
// rtl/l2_word_ram.sv - single-port synchronous word RAM with registered read port
module l2_word_ram
  import l2_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [L2_ADDR_W-1:0] i_addr,
  input  logic [n-1:0]         i_wdata,
  output logic [n-1:0]         o_rdata
);

  logic [n-1:0] r_mem [DEPTH];
  logic [n-1:0] r_rdata;

  // Storage is never cleared; only the output register has a reset value.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_responder.sv
// rtl/l2_responder.sv - fixed-latency L2 word responder behind the coherence arbiter
module l2_responder
  import l2_pkg::*;
#(
  parameter int n       = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 L2_read_request,
  input  logic                 L2_write_request,
  input  logic [L2_ADDR_W-1:0] L2_word_address,
  input  logic [n-1:0]         L2_rdata,
  output logic [n-1:0]         L2_wdata,
  output logic                 L2_busy,
  output logic                 protocol_error,
  output logic [CNT_W-1:0]     read_count,
  output logic [CNT_W-1:0]     write_count
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [LAT_W-1:0]     r_cnt;
  logic [LAT_W-1:0]     w_cnt_next;
  logic [L2_ADDR_W-1:0] r_addr;
  logic [n-1:0]         r_data;
  logic                 r_is_write;
  logic                 r_perr;
  logic [CNT_W-1:0]     r_read_count;
  logic [CNT_W-1:0]     r_write_count;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_enter_done;
  logic                 w_op_write;
  logic [L2_ADDR_W-1:0] w_ram_addr;
  logic [n-1:0]         w_ram_wdata;
  logic                 w_ram_we;
  logic                 w_ram_re;

  assign w_req    = L2_read_request | L2_write_request;
  assign w_accept = (r_state == IDLE) && w_req;

  // With LATENCY=1 the commit happens on the accept edge, so the live inputs
  // must feed the RAM directly instead of the (not yet loaded) latch.
  assign w_op_write  = (r_state == IDLE) ? L2_write_request : r_is_write;
  assign w_ram_addr  = (r_state == IDLE) ? L2_word_address  : r_addr;
  assign w_ram_wdata = (r_state == IDLE) ? L2_rdata         : r_data;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_next = LAT_LOAD;
          if (LATENCY == 1) begin
            w_next_state = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - LAT_W'(1);
        if (w_cnt_next == '0) begin
          w_next_state = DONE;
          w_enter_done = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Reset suppresses the commit so an interrupted write never reaches memory.
  assign w_ram_we = w_enter_done && w_op_write && !reset;
  assign w_ram_re = w_enter_done && !w_op_write && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_is_write    <= 1'b0;
      r_perr        <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= L2_word_address;
        r_data     <= L2_rdata;
        r_is_write <= L2_write_request;
        if (L2_read_request && L2_write_request) begin
          r_perr <= 1'b1;
        end
      end
      if (w_enter_done) begin
        if (w_op_write) begin
          r_write_count <= sat_inc(r_write_count);
        end else begin
          r_read_count <= sat_inc(r_read_count);
        end
      end
    end
  end

  l2_word_ram #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (L2_wdata)
  );

  assign L2_busy        = w_accept || (r_state == WAIT);
  assign protocol_error = r_perr;
  assign read_count     = r_read_count;
  assign write_count    = r_write_count;

endmodule

// File: tb/tb_l2_responder.sv
// tb/tb_l2_responder.sv - scoreboard bench for l2_responder with randomized traffic
`timescale 1ns/1ps
module tb_l2_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd, wr;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy, perr;
  logic [15:0] rc, wc;

  logic        reset1, rd1, wr1;
  logic [9:0]  addr1;
  logic [31:0] din1;
  logic [31:0] dout1;
  logic        busy1, perr1;
  logic [15:0] rc1, wc1;

  l2_responder #(.n(32), .DEPTH(1024), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .L2_read_request(rd), .L2_write_request(wr),
    .L2_word_address(addr), .L2_rdata(din), .L2_wdata(dout), .L2_busy(busy),
    .protocol_error(perr), .read_count(rc), .write_count(wc)
  );

  l2_responder #(.n(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .L2_read_request(rd1), .L2_write_request(wr1),
    .L2_word_address(addr1), .L2_rdata(din1), .L2_wdata(dout1), .L2_busy(busy1),
    .protocol_error(perr1), .read_count(rc1), .write_count(wc1)
  );

  typedef struct {
    logic [31:0] wdata;
    logic [15:0] rc;
    logic [15:0] wc;
    logic        perr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_mem [int];
  int          written[$];
  int          m_rc = 0;
  int          m_wc = 0;
  logic        m_perr = 1'b0;
  logic [31:0] m_last = 32'h0;
  bit          abort_flag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every busy high->low transition marks a DONE cycle.
  bit prev_busy = 1'b0;
  int busy_len  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_len++;
    end else if (prev_busy) begin
      if (abort_flag) begin
        chk("abort_read_count", {16'h0, rc}, 32'h0);
        chk("abort_write_count", {16'h0, wc}, 32'h0);
        chk("abort_perr", {31'h0, perr}, 32'h0);
        chk("abort_wdata", dout, 32'h0);
        abort_flag = 1'b0;
      end else if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("busy_len", busy_len, LAT);
        chk("L2_wdata", dout, e.wdata);
        chk("read_count", {16'h0, rc}, {16'h0, e.rc});
        chk("write_count", {16'h0, wc}, {16'h0, e.wc});
        chk("protocol_error", {31'h0, perr}, {31'h0, e.perr});
      end
      busy_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic scramble();
    rd   = ($urandom & 1) != 0;
    wr   = ($urandom & 1) != 0;
    addr = 10'($urandom);
    din  = $urandom;
  endtask

  // Issue one transaction starting in an IDLE cycle; returns in the IDLE after DONE.
  task automatic txn(input bit r, input bit w, input logic [9:0] a,
                     input logic [31:0] d, input bit hold);
    exp_t e;
    if (w) begin
      m_mem[int'(a)] = d;
      written.push_back(int'(a));
      if (m_wc < 65535) m_wc++;
      if (r) m_perr = 1'b1;
    end else begin
      m_last = m_mem[int'(a)];
      if (m_rc < 65535) m_rc++;
    end
    e.wdata = m_last;
    e.rc    = 16'(m_rc);
    e.wc    = 16'(m_wc);
    e.perr  = m_perr;
    sb_q.push_back(e);
    rd = r; wr = w; addr = a; din = d;
    @(posedge clk) #1;
    repeat (LAT - 1) begin
      if (!hold) scramble();
      @(posedge clk) #1;
    end
    if (!hold) scramble();
    @(posedge clk) #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic abort_write(input logic [9:0] a, input logic [31:0] d);
    rd = 1'b0; wr = 1'b1; addr = a; din = d;
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b1; wr = 1'b0; abort_flag = 1'b1;
    m_rc = 0; m_wc = 0; m_perr = 1'b0; m_last = 32'h0;
    @(posedge clk) #1;
    reset = 1'b0;
  endtask

  initial begin
    int r, a;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    reset1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_wdata", dout, 32'h0);
    chk("reset_read_count", {16'h0, rc}, 32'h0);
    chk("reset_write_count", {16'h0, wc}, 32'h0);
    chk("reset_perr", {31'h0, perr}, 32'h0);
    @(posedge clk) #1;
    reset = 1'b0; reset1 = 1'b0;
    @(posedge clk) #1;

    txn(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 1'b0, 10'h005, 32'h0, 1'b1);
    txn(1'b1, 1'b0, 10'h005, 32'h0, 1'b0);
    txn(1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0);
    txn(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 10'h00A, 32'h11111111, 1'b0);
    abort_write(10'h00A, 32'hCAFEF00D);
    @(negedge clk);
    chk("post_abort_busy", {31'h0, busy}, 32'h0);
    @(posedge clk) #1;
    txn(1'b1, 1'b0, 10'h00A, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        txn(1'b1, 1'b1, 10'($urandom), $urandom, 1'b0);
      end else if (r < 45) begin
        txn(1'b0, 1'b1, 10'($urandom), $urandom, 1'b0);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        txn(1'b1, 1'b0, 10'(a), $urandom, ($urandom & 1) != 0);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk) #1;
    end

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk) #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    // LATENCY=1 build: busy only in the accept cycle, data valid the next one.
    rd1 = 1'b0; wr1 = 1'b1; addr1 = 10'h007; din1 = 32'h000000AA;
    @(negedge clk);
    chk("lat1_wr_busy_accept", {31'h0, busy1}, 32'h1);
    @(posedge clk) #1;
    wr1 = 1'b0;
    @(negedge clk);
    chk("lat1_wr_busy_done", {31'h0, busy1}, 32'h0);
    chk("lat1_write_count", {16'h0, wc1}, 32'h1);
    chk("lat1_wdata_after_write", dout1, 32'h0);
    @(posedge clk) #1;
    rd1 = 1'b1;
    @(negedge clk);
    chk("lat1_rd_busy_accept", {31'h0, busy1}, 32'h1);
    @(posedge clk) #1;
    rd1 = 1'b0;
    @(negedge clk);
    chk("lat1_rd_busy_done", {31'h0, busy1}, 32'h0);
    chk("lat1_rdata", dout1, 32'h000000AA);
    chk("lat1_read_count", {16'h0, rc1}, 32'h1);

    @(posedge clk) #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
